array_drain: RTL and testbench

ARRAY_DRAIN -- requirements
Module: array_drain

---
 rtl/array_drain.sv | 233 +++++++++++++++++++++++
 tb/tb_array_drain.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_drain.sv
// ============================================================================
// array_drain
// ----------------------------------------------------------------------------
// Drains the bottom row of a systolic array. Column k of a row arrives k
// cycles after column 0, so each column is delayed by NUM_COLS-1-k cycles
// (and the row valid by NUM_COLS-1 cycles) to re-align the row. Aligned rows
// are pushed into a small FIFO whose head is held in output registers.
// The array cannot be stalled: a row arriving at a full FIFO with no pop in
// the same cycle is dropped and a sticky overflow flag is raised.
//
// Optional build macro:
//   DRAIN_RELU_EN - each word written to the FIFO is forced to zero when its
//                   MSB is set (negative in two's complement). Timing is the
//                   same with and without the macro.
//
// Ports:
//   clk_i        in   1                   clock, rising edge
//   rst_i        in   1                   asynchronous active-high reset
//   col_data_i   in   NUM_COLS*NUM_BITS   skewed column outputs, column k at
//                                         [k*NUM_BITS +: NUM_BITS]
//   in_valid_i   in   1                   column 0 carries row data this cycle
//   row_o        out  NUM_COLS*NUM_BITS   deskewed row at the FIFO head
//   row_valid_o  out  1                   row_o is valid
//   row_ready_i  in   1                   consumer accepts row_o
//   count_o      out  $clog2(DEPTH)+1     FIFO occupancy
//   overflow_o   out  1                   sticky: a row was dropped
//   clr_i        in   1                   synchronous clear of overflow_o
// ============================================================================

package array_drain_pkg;
    localparam int NUM_BITS = 8;
endpackage

module array_drain #(
    parameter int NUM_BITS = array_drain_pkg::NUM_BITS,
    parameter int NUM_COLS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_COLS*NUM_BITS-1:0]   col_data_i,
    input  logic                           in_valid_i,
    output logic [NUM_COLS*NUM_BITS-1:0]   row_o,
    output logic                           row_valid_o,
    input  logic                           row_ready_i,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           overflow_o,
    input  logic                           clr_i
);

    localparam int RW = NUM_COLS * NUM_BITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

`ifdef DRAIN_RELU_EN
    // Clamp a negative two's-complement word to zero.
    function automatic logic [NUM_BITS-1:0] relu_word(input logic [NUM_BITS-1:0] w);
        logic [NUM_BITS-1:0] r;
        if (w[NUM_BITS-1]) begin
            r = '0;
        end else begin
            r = w;
        end
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Deskew pipeline
    // ------------------------------------------------------------------
    logic [NUM_COLS-2:0] vld_r;
    logic [RW-1:0]       aligned_raw_s;
    logic [RW-1:0]       aligned_s;
    logic                aligned_valid_s;

    // Row valid travels alongside column 0, so it sees the longest delay.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_r <= '0;
        end else begin
            vld_r[0] <= in_valid_i;
            for (int j = 1; j < NUM_COLS - 1; j++) begin
                vld_r[j] <= vld_r[j-1];
            end
        end
    end

    assign aligned_valid_s = vld_r[NUM_COLS-2];

    for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
        if (k == NUM_COLS - 1) begin : g_direct
            // The last column arrives already aligned with the delayed valid.
            assign aligned_raw_s[k*NUM_BITS +: NUM_BITS] = col_data_i[k*NUM_BITS +: NUM_BITS];
        end else begin : g_delay
            localparam int D = NUM_COLS - 1 - k;
            logic [NUM_BITS-1:0] dly_r [D];

            // Shift register delaying this column by D cycles.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int j = 0; j < D; j++) begin
                        dly_r[j] <= '0;
                    end
                end else begin
                    dly_r[0] <= col_data_i[k*NUM_BITS +: NUM_BITS];
                    for (int j = 1; j < D; j++) begin
                        dly_r[j] <= dly_r[j-1];
                    end
                end
            end

            assign aligned_raw_s[k*NUM_BITS +: NUM_BITS] = dly_r[D-1];
        end
    end

    // Optional per-word ReLU on the aligned row before it enters the FIFO.
    always_comb begin
        aligned_s = aligned_raw_s;
`ifdef DRAIN_RELU_EN
        for (int k = 0; k < NUM_COLS; k++) begin
            aligned_s[k*NUM_BITS +: NUM_BITS] = relu_word(aligned_raw_s[k*NUM_BITS +: NUM_BITS]);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Row FIFO with registered head
    // ------------------------------------------------------------------
    logic [RW-1:0] mem_r [DEPTH];
    ptr_t          wr_ptr_r;
    ptr_t          rd_ptr_r;
    ptr_t          wr_ptr_next_s;
    ptr_t          rd_ptr_next_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic [RW-1:0] row_r;
    logic [RW-1:0] head_next_s;
    logic          row_valid_r;
    logic          overflow_r;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;

    // Push/pop decisions and next-state of pointers, occupancy and head.
    always_comb begin
        pop_s  = row_valid_r & row_ready_i;
        full_s = (count_r == FULL_CNT);
        // A full FIFO still accepts a row when its head leaves in the same cycle.
        push_s = aligned_valid_s & (~full_s | pop_s);
        drop_s = aligned_valid_s & full_s & ~pop_s;

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PW'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PW'(1'b1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase

        // The next head is the incoming row when it lands in the slot the
        // read pointer is about to point at (empty FIFO, or one entry popped).
        if (count_next_s == '0) begin
            head_next_s = row_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = aligned_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= aligned_s;
            end
        end
    end

    // Pointers, occupancy and registered head outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            row_r       <= '0;
            row_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            row_r       <= head_next_s;
            row_valid_r <= (count_next_s != '0);
        end
    end

    // Sticky overflow; a new drop wins over a coinciding clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_i) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign row_o       = row_r;
    assign row_valid_o = row_valid_r;
    assign count_o     = count_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_array_drain.sv
// Self-checking bench for array_drain (NUM_BITS=8, NUM_COLS=4, DEPTH=4).
// Expected rows are queued when driven and compared when the DUT pops them.
module tb_array_drain;

    localparam int NB  = 8;
    localparam int NC  = 4;
    localparam int DEP = 4;
    localparam int RW  = NB * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] col_data;
    logic          in_valid;
    logic [RW-1:0] row;
    logic          row_valid;
    logic          row_ready;
    logic [2:0]    count;
    logic          overflow;
    logic          clr;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] rows_buf [16];
    logic [31:0]   relu_exp;

    always #5 clk = ~clk;

    array_drain #(
        .NUM_BITS(NB),
        .NUM_COLS(NC),
        .DEPTH   (DEP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .col_data_i (col_data),
        .in_valid_i (in_valid),
        .row_o      (row),
        .row_valid_o(row_valid),
        .row_ready_i(row_ready),
        .count_o    (count),
        .overflow_o (overflow),
        .clr_i      (clr)
    );

    function automatic logic [RW-1:0] model_row(input logic [RW-1:0] r);
        logic [RW-1:0] m;
        m = r;
`ifdef DRAIN_RELU_EN
        for (int k = 0; k < NC; k++) begin
            if (r[k*NB + NB - 1]) m[k*NB +: NB] = '0;
        end
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted pop is compared with the oldest expected row.
    always @(negedge clk) begin
        if (!rst && row_valid && row_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_row", 32'(exp_q.size()), 32'd1);
            end else begin
                check("row_data", row, exp_q.pop_front());
            end
        end
    end

    // Drive n rows (rows_buf[0..n-1]) with the array's column skew; the first
    // `keep` rows are expected to reach the output. rdy_at / clr_at select a
    // single drive cycle where ready / clr are high (-1: leave ready alone).
    task automatic drive_rows(input int n, input int keep, input int rdy_at,
                              input int clr_at, input bit chk_idle);
        for (int c = 0; c < n + NC - 1; c++) begin
            tick();
            in_valid = (c < n);
            for (int k = 0; k < NC; k++) begin
                int r;
                r = c - k;
                if (r >= 0 && r < n) col_data[k*NB +: NB] = rows_buf[r][k*NB +: NB];
                else col_data[k*NB +: NB] = 8'($urandom);
            end
            if (c < n && c < keep) exp_q.push_back(model_row(rows_buf[c]));
            if (rdy_at >= 0) row_ready = (c == rdy_at);
            clr = (c == clr_at);
            if (chk_idle) begin
                @(negedge clk);
                check("valid_idle", 32'(row_valid), 32'd0);
            end
        end
        tick();
        in_valid = 1'b0;
        col_data = RW'($urandom);
        clr      = 1'b0;
        if (rdy_at >= 0) row_ready = 1'b0;
    endtask

    // Hold ready high until every expected row has been popped (bounded).
    task automatic drain(input int budget);
        int i = 0;
        tick();
        row_ready = 1'b1;
        while (exp_q.size() > 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        tick();
        @(negedge clk);
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(row_valid), 32'd0);
        tick();
    endtask

    task automatic fill_full();
        for (int i = 0; i < 4; i++) rows_buf[i] = RW'($urandom);
        row_ready = 1'b0;
        drive_rows(4, 4, -1, -1, 1'b0);
        @(negedge clk);
        check("fill_count", 32'(count), 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        col_data  = '0;
        row_ready = 1'b0;
        clr       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row",      row,             32'h0);
        check("rst_valid",    32'(row_valid),  32'd0);
        check("rst_count",    32'(count),      32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        tick();
        rst = 1'b0;

        // Single row: valid exactly in cycle 4.
        rows_buf[0] = {8'h44, 8'h33, 8'h22, 8'h11};
        row_ready = 1'b1;
        n_out = 0;
        drive_rows(1, 1, -1, -1, 1'b1);
        @(negedge clk);
        check("single_valid_c4", 32'(row_valid), 32'd1);
        check("single_row",      row,            32'h44332211);
        tick();
        @(negedge clk);
        check("single_valid_c5", 32'(row_valid), 32'd0);
        check("single_nout",     32'(n_out),     32'd1);

        // Burst of 6 with ready low: 4 stored, 2 dropped.
        for (int i = 0; i < 6; i++) rows_buf[i] = RW'($urandom);
        row_ready = 1'b0;
        drive_rows(6, 4, -1, -1, 1'b0);
        @(negedge clk);
        check("burst_count",    32'(count),    32'd4);
        check("burst_overflow", 32'(overflow), 32'd1);
        n_out = 0;
        drain(20);
        check("burst_nout", 32'(n_out), 32'd4);

        // Clear with no drop.
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_overflow", 32'(overflow), 32'd0);

        // Full FIFO, pop coinciding with an arrival.
        n_out = 0;
        fill_full();
        check("full_overflow0", 32'(overflow), 32'd0);
        rows_buf[0] = RW'($urandom);
        drive_rows(1, 1, NC - 1, -1, 1'b0);
        @(negedge clk);
        check("fullpop_count",    32'(count),    32'd4);
        check("fullpop_overflow", 32'(overflow), 32'd0);
        drain(20);
        check("fullpop_nout", 32'(n_out), 32'd5);

        // Clear coinciding with a drop: overflow stays set.
        fill_full();
        rows_buf[0] = RW'($urandom);
        drive_rows(1, 0, -1, NC - 1, 1'b0);
        @(negedge clk);
        check("clrdrop_overflow", 32'(overflow), 32'd1);
        check("clrdrop_count",    32'(count),    32'd4);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clrdrop_cleared", 32'(overflow), 32'd0);
        drain(20);

        // Back-to-back stream with ready high (pointer wrap, push+pop).
        n_out = 0;
        for (int i = 0; i < 10; i++) rows_buf[i] = RW'($urandom);
        drive_rows(10, 10, -1, -1, 1'b0);
        drain(20);
        check("stream_nout", 32'(n_out), 32'd10);

        // Negative word in column 1.
        rows_buf[0] = {8'h05, 8'h05, 8'h80, 8'h05};
`ifdef DRAIN_RELU_EN
        relu_exp = 32'h05050005;
`else
        relu_exp = 32'h05058005;
`endif
        drive_rows(1, 1, -1, -1, 1'b0);
        @(negedge clk);
        check("relu_valid", 32'(row_valid), 32'd1);
        check("relu_row",   row,            relu_exp);
        drain(20);

        // Reset in cycle 2 of a row: it must never emerge.
        n_out = 0;
        tick();
        in_valid = 1'b1;
        col_data = {8'hAA, 8'hAA, 8'hAA, 8'h11};
        tick();
        in_valid = 1'b0;
        col_data = {8'hAA, 8'hAA, 8'h22, 8'hAA};
        tick();
        col_data = {8'hAA, 8'h33, 8'hAA, 8'hAA};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        col_data = {8'h44, 8'hAA, 8'hAA, 8'hAA};
        tick();
        col_data = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_valid", 32'(row_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_nout",  32'(n_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
